// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// Shared constants for the UART baud-rate tick generator and its consumers.
package uart_pkg;

  localparam int DIV_W = 16;
  localparam int OSR   = 16;
  localparam int OSR_W = $clog2(OSR);

  // Example divisors for a 50 MHz system clock.
  localparam logic [DIV_W-1:0] DIV_9600_50M   = 16'd325;
  localparam logic [DIV_W-1:0] DIV_115200_50M = 16'd27;

  // Counter width for a modulo-OSR counter; never less than one bit.
  function automatic int osr_bits(input int osr);
    return (osr > 1) ? $clog2(osr) : 1;
  endfunction

endpackage

// File: rtl/uart_tick_div.sv
`timescale 1ns/1ps
// Generic modulo counter: counts enabled cycles from 0 up to 'last', then reloads.
// tc is the combinational terminal-count strobe for the cycle that reloads.
module uart_tick_div #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic         tc
);

  logic [W-1:0] count;

  // A 'last' that drops below the running count ends the period at once
  // instead of letting the counter run round the full range.
  assign tc = en && !clr && (count >= last);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count <= '0;
    end else if (tc) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/uart_baud_gen.sv
`timescale 1ns/1ps
// UART baud tick generator: rx_tick every i_divisor clocks (16x oversample),
// tx_tick once per OSR rx_ticks, both registered one-cycle strobes.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV_W = uart_pkg::DIV_W,
  parameter int OSR   = uart_pkg::OSR
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] i_divisor,
  output logic             rx_tick,
  output logic             tx_tick
);

  localparam int OS_W = osr_bits(OSR);

  logic             div_zero;
  logic [DIV_W-1:0] div_last;
  logic             pre_tc;
  logic             os_tc;

  // A zero divisor parks the prescaler at 0; the underflowed 'last' is never used.
  assign div_zero = (i_divisor == '0);
  assign div_last = i_divisor - DIV_W'(1);

  uart_tick_div #(
    .W(DIV_W)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (div_zero),
    .en   (1'b1),
    .last (div_last),
    .tc   (pre_tc)
  );

  uart_tick_div #(
    .W(OS_W)
  ) u_oversampler (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (1'b0),
    .en   (rx_tick),
    .last (OS_W'(OSR - 1)),
    .tc   (os_tc)
  );

  // tx_tick lands one clock after the rx_tick that completes each group.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_tick <= 1'b0;
      tx_tick <= 1'b0;
    end else begin
      rx_tick <= pre_tc;
      tx_tick <= os_tc;
    end
  end

endmodule

// File: tb/tb_uart_baud_gen.sv
`timescale 1ns/1ps
// Scoreboard bench for uart_baud_gen: stimulus queues expected tick spacings,
// a monitor measures spacing between ticks and compares against the queue.
module tb_uart_baud_gen;
  import uart_pkg::*;

  typedef struct {
    string name;
    int    gap;
    int    rx_count;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] i_divisor;
  logic        rx_tick;
  logic        tx_tick;

  exp_t rx_q[$];
  exp_t tx_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_rx = 0;
  int   last_tx = 0;
  int   rx_since_tx = 0;
  bit   rx_strict = 1'b0;
  bit   tx_strict = 1'b0;

  uart_baud_gen #(
    .DIV_W(16),
    .OSR  (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_divisor(i_divisor),
    .rx_tick  (rx_tick),
    .tx_tick  (tx_tick)
  );

  always #10 clk = ~clk;

  task automatic compareInt(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic act, input logic exp);
    compareInt(name, int'(act), int'(exp));
  endtask

  task automatic applyStimulus(input logic rstn_v, input logic [15:0] div_v);
    rst_n     = rstn_v;
    i_divisor = div_v;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic pushRx(input string name, input int gap, input int n);
    for (int i = 0; i < n; i++) rx_q.push_back('{name, gap, -1});
  endtask

  task automatic pushTx(input string name, input int gap, input int rx_count);
    tx_q.push_back('{name, gap, rx_count});
  endtask

  task automatic waitDrain(input string name, input int limit);
    int n = 0;
    while ((rx_q.size() != 0 || tx_q.size() != 0) && n < limit) begin
      @(posedge clk);
      #3;
      n++;
    end
    if (rx_q.size() != 0 || tx_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout: got %0d rx and %0d tx ticks outstanding after %0d cycles, required 0",
               name, rx_q.size(), tx_q.size(), limit);
      rx_q.delete();
      tx_q.delete();
    end
  endtask

  // Monitor: sample 1 ns after each rising edge, measure spacing, pop and compare.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (!rst_n) begin
      if (rx_tick || tx_tick) begin
        checks++;
        errors++;
        $display("[TB] FAIL tick_in_reset at cycle %0d: got rx=%0b tx=%0b, required 0", cyc, rx_tick, tx_tick);
      end
      last_rx     = cyc;
      last_tx     = cyc;
      rx_since_tx = 0;
    end else begin
      if (tx_tick) begin
        if (tx_q.size() != 0) begin
          mon_e = tx_q.pop_front();
          if (mon_e.gap >= 0) compareInt({mon_e.name, "_gap"}, cyc - last_tx, mon_e.gap);
          if (mon_e.rx_count >= 0) compareInt({mon_e.name, "_rx_per_tx"}, rx_since_tx, mon_e.rx_count);
        end else if (tx_strict) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_tx_tick at cycle %0d: got 1, required 0", cyc);
        end
        last_tx     = cyc;
        rx_since_tx = 0;
      end
      if (rx_tick) begin
        if (rx_q.size() != 0) begin
          mon_e = rx_q.pop_front();
          if (mon_e.gap >= 0) compareInt({mon_e.name, "_gap"}, cyc - last_rx, mon_e.gap);
        end else if (rx_strict) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_rx_tick at cycle %0d: got 1, required 0", cyc);
        end
        last_rx = cyc;
        rx_since_tx++;
      end
    end
  end

  initial begin
    int d;
    applyStimulus(1'b0, DIV_9600_50M);

    // Reset held for 10 clocks, then 9600 baud and 115200 baud spacing.
    for (int i = 0; i < 10; i++) begin
      waitCycles(1);
      checkOutput("reset_rx", rx_tick, 1'b0);
      checkOutput("reset_tx", tx_tick, 1'b0);
    end
    pushRx("first_rx_325", 325, 1);
    pushRx("rx_325", 325, 3);
    rx_strict = 1'b1;
    applyStimulus(1'b1, DIV_9600_50M);
    waitDrain("rate_325", 1500);
    applyStimulus(1'b1, DIV_115200_50M);
    pushRx("rx_27", 27, 6);
    waitDrain("rate_27", 300);

    // 16 rx_ticks per tx_tick; tx lags the 16th rx_tick by one clock.
    applyStimulus(1'b0, 16'd100);
    for (int i = 0; i < 3; i++) begin
      waitCycles(1);
      checkOutput("reset2_rx", rx_tick, 1'b0);
      checkOutput("reset2_tx", tx_tick, 1'b0);
    end
    pushRx("ratio_rx", 100, 32);
    pushTx("ratio_tx_first", 1601, 16);
    pushTx("ratio_tx", 1600, 16);
    tx_strict = 1'b1;
    applyStimulus(1'b1, 16'd100);
    waitDrain("ratio", 4000);
    tx_strict = 1'b0;

    // Count is 1 here; at count 70 drop the divisor to 50, then raise to 200 mid-period.
    waitCycles(69);
    applyStimulus(1'b1, 16'd50);
    pushRx("switch_short", 71, 1);
    pushRx("switch_50", 50, 4);
    waitDrain("switch", 400);
    waitCycles(40);
    applyStimulus(1'b1, 16'd200);
    pushRx("grow_200", 200, 1);
    waitDrain("grow", 300);

    // Minimum divisor 2.
    applyStimulus(1'b0, 16'd2);
    for (int i = 0; i < 3; i++) begin
      waitCycles(1);
      checkOutput("reset3_rx", rx_tick, 1'b0);
    end
    pushRx("div_2", 2, 40);
    pushTx("tx_div2_first", 33, 16);
    pushTx("tx_div2", 32, 16);
    tx_strict = 1'b1;
    applyStimulus(1'b1, 16'd2);
    waitDrain("div_2", 200);
    tx_strict = 1'b0;

    // Divisor 1 holds rx_tick high.
    rx_strict = 1'b0;
    applyStimulus(1'b1, 16'd1);
    waitCycles(1);
    for (int i = 0; i < 20; i++) begin
      checkOutput("div1_rx", rx_tick, 1'b1);
      waitCycles(1);
    end

    // Divisor 0 disables both ticks; then restart at 10.
    applyStimulus(1'b1, 16'd0);
    waitCycles(2);
    rx_strict = 1'b1;
    tx_strict = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      waitCycles(1);
      checkOutput("div0_rx", rx_tick, 1'b0);
      checkOutput("div0_tx", tx_tick, 1'b0);
    end
    tx_strict = 1'b0;
    applyStimulus(1'b1, 16'd10);
    pushRx("restart_first", 1012, 1);
    pushRx("restart_10", 10, 2);
    waitDrain("restart", 100);

    // Random divisors, changed right after a tick so both periods equal the divisor.
    for (int it = 0; it < 20; it++) begin
      d = int'($urandom_range(500, 10));
      applyStimulus(1'b1, 16'(d));
      pushRx("rand", d, 2);
      waitDrain("rand", 2 * d + 20);
    end

    // Reset on the cycle a tick is due: it must be suppressed, then restart cleanly.
    applyStimulus(1'b1, 16'd100);
    pushRx("pre_reset_100", 100, 1);
    waitDrain("pre_reset", 300);
    waitCycles(99);
    applyStimulus(1'b0, 16'd100);
    for (int i = 0; i < 5; i++) begin
      waitCycles(1);
      checkOutput("midreset_rx", rx_tick, 1'b0);
      checkOutput("midreset_tx", tx_tick, 1'b0);
    end
    pushRx("post_reset", 100, 2);
    applyStimulus(1'b1, 16'd100);
    waitDrain("post_reset", 300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion by 2 ms, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/uart_baud_gen.md
Name: uart_baud_gen

Overview:
UART baud-rate tick generator. It divides the system clock by a runtime-programmable 16-bit divisor to produce the receiver's 16x oversampling tick (rx_tick). It then divides rx_tick by 16 to produce the transmitter's bit tick (tx_tick). It sits between the register block, which supplies the divisor, and the UART TX/RX engines, which consume the one-cycle tick strobes. Example: at 50 MHz, divisor 325 gives 9600 bps and divisor 27 gives 115200 bps.

Parameters:
DIV_W, 16, width of the divisor and of the prescale counter
OSR, 16, oversampling ratio (number of rx_ticks per tx_tick)

Ports:
clk  input  1  system clock; all logic on its rising edge
rst_n  input  1  reset, synchronous, active-low
i_divisor  input  DIV_W  clocks per rx_tick; sampled every cycle, never latched
rx_tick  output  1  one-clock-wide strobe, once every i_divisor clocks
tx_tick  output  1  one-clock-wide strobe, once every OSR rx_ticks

Behaviour:
- Reset: reset is synchronous, active-low. While rst_n=0 at a clock edge, the prescale counter, the oversample counter, rx_tick and tx_tick all clear to 0. Both outputs read 0 for the whole reset interval.
- Prescale counter (DIV_W bits), evaluated every cycle:
  - if the counter is >= i_divisor-1: it reloads to 0 and rx_tick is asserted (registered) for exactly one cycle;
  - otherwise it increments and rx_tick is 0.
- rx_tick period is exactly i_divisor clocks, i.e. i_divisor x T_clk. The first rx_tick after reset release occurs i_divisor clocks after the first non-reset edge.
- The compare uses >=, not ==. A divisor that drops below the current count therefore takes effect on the next cycle: one short period, no 65536-cycle wrap. A divisor increase extends the current period.
- i_divisor=1: rx_tick is held high continuously.
- i_divisor=0: the generator is disabled. The prescale counter holds at 0 and rx_tick and tx_tick stay 0. The counter never underflows.
- Oversample counter (log2(OSR) bits) increments on each rx_tick and wraps OSR-1 -> 0.
- tx_tick is registered from "rx_tick asserted and oversample count == OSR-1". It is a one-cycle strobe lagging the 16th rx_tick by one clock. Exactly 16 rx_ticks therefore precede each tx_tick, and tx_tick never coincides with the rx_tick that completes the group.
- tx_tick period is 16 x i_divisor clocks in steady state.
- A divisor change does not reset the oversample counter.
- Reset mid-operation clears both counters immediately (next edge) and suppresses any pending tick.
- Minimum supported operating divisor is 2, giving rx_tick every 2 clocks (50% duty).

Decomposition:
- Shared package uart_pkg:
  - constants DIV_W=16 and OSR=16;
  - localparam OSR_W=$clog2(OSR);
  - example divisor constants DIV_9600_50M=325 and DIV_115200_50M=27.
- One natural sub-module: uart_tick_div, a generic modulo-N counter with an enable input and a one-cycle terminal-count strobe.
  - instance 1: prescaler, enable=1, N=i_divisor;
  - instance 2: oversampler, enable=rx_tick, N=OSR.
- The top level adds the tx_tick output register and the divisor=0 gating.

Test Plan:
- Reset check: rst_n=0 for 10 clocks with i_divisor=325 -> rx_tick=0 and tx_tick=0 throughout; release -> first rx_tick 325 clocks later.
- Standard rate: 50 MHz clock (20 ns), i_divisor=325 -> successive rx_tick rising edges are 6500 ns apart. Then i_divisor=27 -> spacing of 540 ns.
- Ratio: i_divisor=100; count rx_tick pulses between consecutive tx_ticks -> exactly 16, with tx_tick period 1600 clocks (32000 ns) over at least 2 tx_ticks.
- Dynamic switch: running at i_divisor=100, change to 50 mid-period -> no wrap to 65536; from the second following rx_tick, spacing is 1000 ns.
- Boundaries: i_divisor=2 -> rx_tick every 2 clocks (40 ns), tx_tick every 32 clocks. i_divisor=1 -> rx_tick constantly 1. i_divisor=0 -> no ticks for 1000 clocks.
- Random stress: 20 iterations with i_divisor uniform in [10,500], each checked after 2 rx_ticks -> period == i_divisor x 20 ns. Also assert reset mid-period -> ticks stop on the next edge and restart cleanly.
